// File: rtl/ipsl_ddrphy_update_exec.sv
// PHY-side executor for PHY-initiated updates: DFI phyupd handshake, DLL re-lock pulse or DQS tap adjust.
// Optional per-type completion counters are enabled by defining IPSL_DDRPHY_UPD_STATS_EN.
module ipsl_ddrphy_update_exec #(
    parameter string       DATA_WIDTH    = "16BIT",
    parameter int unsigned DLL_PULSE_CYC = 8,
    parameter int unsigned SETTLE_CYC    = 16,
    parameter logic [7:0]  DLY_INIT      = 8'd64,
    parameter logic [7:0]  DLY_MAX       = 8'd127,
    parameter int unsigned ACK_TIMEOUT   = 255
) (
    input  logic       rclk,
    input  logic       rst_n,
    input  logic       update_start,
    input  logic [1:0] ddrphy_update_type,
    input  logic [1:0] ddrphy_update_comp_val_l,
    input  logic       ddrphy_update_comp_dir_l,
    input  logic [1:0] ddrphy_update_comp_val_h,
    input  logic       ddrphy_update_comp_dir_h,
    output logic       ddrphy_update_done,
    output logic       dfi_phyupd_req,
    input  logic       dfi_phyupd_ack,
    output logic       dll_update_n,
    output logic [7:0] dqs_rd_dly_l,
    output logic [7:0] dqs_rd_dly_h,
    output logic       dqs_dly_load,
    output logic       upd_timeout
`ifdef IPSL_DDRPHY_UPD_STATS_EN
    ,
    output logic [15:0] upd_cnt_dll,
    output logic [15:0] upd_cnt_dqs,
    output logic [15:0] upd_cnt_man
`endif
);

    localparam int unsigned CNT_W  = 16;
    localparam bit          HAS_HI = (DATA_WIDTH != "8BIT");

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_DLL_PULSE, S_DQS_ADJ, S_SETTLE, S_DONE, S_WAIT_LOW
    } state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               w_capture, w_timeout_evt;
    logic [1:0]         r_type, r_val_l, r_val_h;
    logic               r_dir_l, r_dir_h;
    logic               r_done, r_req, r_dll_n, r_load, r_timeout;
    logic [7:0]         r_dly_l, r_dly_h;

    // Saturating tap step computed 9 bits wide so neither end can wrap.
    function automatic logic [7:0] f_adj(input logic [7:0] dly, input logic [1:0] val, input logic up);
        logic [8:0] sum;
        logic [8:0] dif;
        sum = {1'b0, dly} + {7'd0, val};
        dif = {1'b0, dly} - {7'd0, val};
        if (up) f_adj = (sum > {1'b0, DLY_MAX}) ? DLY_MAX : sum[7:0];
        else    f_adj = dif[8] ? 8'd0 : dif[7:0];
    endfunction

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_cnt_nxt     = '0;
        w_capture     = 1'b0;
        w_timeout_evt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (update_start) begin
                    w_capture = 1'b1;
                    w_next    = S_REQ;
                end
            end
            S_REQ: begin
                if (dfi_phyupd_ack) begin
                    case (r_type)
                        2'b00:   w_next = S_DLL_PULSE;
                        2'b01:   w_next = S_DQS_ADJ;
                        default: w_next = S_SETTLE;
                    endcase
                end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    w_timeout_evt = 1'b1;
                    w_next        = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DLL_PULSE: begin
                if (r_cnt == CNT_W'(DLL_PULSE_CYC - 1)) w_next = S_SETTLE;
                else w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            S_DQS_ADJ: w_next = S_SETTLE;
            S_SETTLE: begin
                if (r_cnt == CNT_W'(SETTLE_CYC - 1)) w_next = S_DONE;
                else w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            S_DONE: w_next = S_WAIT_LOW;
            // Hold off until the requester drops its level so it cannot retrigger.
            S_WAIT_LOW: begin
                if (!update_start) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_type  <= '0;
            r_val_l <= '0;
            r_dir_l <= 1'b0;
            r_val_h <= '0;
            r_dir_h <= 1'b0;
        end else if (w_capture) begin
            r_type  <= ddrphy_update_type;
            r_val_l <= ddrphy_update_comp_val_l;
            r_dir_l <= ddrphy_update_comp_dir_l;
            r_val_h <= ddrphy_update_comp_val_h;
            r_dir_h <= ddrphy_update_comp_dir_h;
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_req     <= 1'b0;
            r_dll_n   <= 1'b1;
            r_load    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_dly_l   <= DLY_INIT;
            r_dly_h   <= DLY_INIT;
        end else begin
            r_req   <= (w_next == S_REQ) || (w_next == S_DLL_PULSE) ||
                       (w_next == S_DQS_ADJ) || (w_next == S_SETTLE);
            r_dll_n <= (w_next != S_DLL_PULSE);
            r_load  <= (w_next == S_DQS_ADJ);
            r_done  <= (r_state == S_DONE);
            if (w_timeout_evt) r_timeout <= 1'b1;
            if (w_next == S_DQS_ADJ) begin
                r_dly_l <= f_adj(r_dly_l, r_val_l, r_dir_l);
                if (HAS_HI) r_dly_h <= f_adj(r_dly_h, r_val_h, r_dir_h);
            end
        end
    end

    assign ddrphy_update_done = r_done;
    assign dfi_phyupd_req     = r_req;
    assign dll_update_n       = r_dll_n;
    assign dqs_dly_load       = r_load;
    assign upd_timeout        = r_timeout;
    assign dqs_rd_dly_l       = r_dly_l;
    assign dqs_rd_dly_h       = r_dly_h;

`ifdef IPSL_DDRPHY_UPD_STATS_EN
    logic        r_to_cur;
    logic [15:0] r_cnt_dll, r_cnt_dqs, r_cnt_man;

    // Per-type completion counters; the current update's own timeout excludes it.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cur  <= 1'b0;
            r_cnt_dll <= '0;
            r_cnt_dqs <= '0;
            r_cnt_man <= '0;
        end else begin
            if (w_capture) r_to_cur <= 1'b0;
            else if (w_timeout_evt) r_to_cur <= 1'b1;
            if ((r_state == S_DONE) && !r_to_cur) begin
                case (r_type)
                    2'b00:   if (r_cnt_dll != 16'hFFFF) r_cnt_dll <= r_cnt_dll + 16'd1;
                    2'b01:   if (r_cnt_dqs != 16'hFFFF) r_cnt_dqs <= r_cnt_dqs + 16'd1;
                    default: if (r_cnt_man != 16'hFFFF) r_cnt_man <= r_cnt_man + 16'd1;
                endcase
            end
        end
    end

    assign upd_cnt_dll = r_cnt_dll;
    assign upd_cnt_dqs = r_cnt_dqs;
    assign upd_cnt_man = r_cnt_man;
`endif

endmodule

// File: tb/tb_ipsl_ddrphy_update_exec.sv
// Scoreboard bench for ipsl_ddrphy_update_exec: randomized updates against a tap/latency reference model.
module tb_ipsl_ddrphy_update_exec;

    logic       rclk = 1'b0;
    logic       rst_n;
    logic       update_start;
    logic [1:0] typ, val_l, val_h;
    logic       dir_l, dir_h;
    logic       ack;

    logic       done, req, dll_n, load, tout;
    logic [7:0] dly_l, dly_h;
    logic       done8, req8, dll_n8, load8, tout8;
    logic [7:0] dly_l8, dly_h8;

    always #5 rclk = ~rclk;

    ipsl_ddrphy_update_exec u_dut (
        .rclk(rclk), .rst_n(rst_n), .update_start(update_start),
        .ddrphy_update_type(typ),
        .ddrphy_update_comp_val_l(val_l), .ddrphy_update_comp_dir_l(dir_l),
        .ddrphy_update_comp_val_h(val_h), .ddrphy_update_comp_dir_h(dir_h),
        .ddrphy_update_done(done), .dfi_phyupd_req(req), .dfi_phyupd_ack(ack),
        .dll_update_n(dll_n), .dqs_rd_dly_l(dly_l), .dqs_rd_dly_h(dly_h),
        .dqs_dly_load(load), .upd_timeout(tout)
    );

    ipsl_ddrphy_update_exec #(.DATA_WIDTH("8BIT")) u_dut8 (
        .rclk(rclk), .rst_n(rst_n), .update_start(update_start),
        .ddrphy_update_type(typ),
        .ddrphy_update_comp_val_l(val_l), .ddrphy_update_comp_dir_l(dir_l),
        .ddrphy_update_comp_val_h(val_h), .ddrphy_update_comp_dir_h(dir_h),
        .ddrphy_update_done(done8), .dfi_phyupd_req(req8), .dfi_phyupd_ack(ack),
        .dll_update_n(dll_n8), .dqs_rd_dly_l(dly_l8), .dqs_rd_dly_h(dly_h8),
        .dqs_dly_load(load8), .upd_timeout(tout8)
    );

    typedef struct {
        int     l;
        int     h;
        bit     to;
        int     lat;
        int     dll_lo;
        int     loads;
        int     req_hi;
        longint start_cyc;
    } exp_t;

    exp_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     ack_dly = 0;
    int     reqcyc = 0;
    int     m_l = 64, m_h = 64;
    bit     m_to = 1'b0;
    int     mon_req = 0, mon_dll = 0, mon_load = 0;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int step(input int d, input int v, input bit up);
        if (up) return (d + v > 127) ? 127 : d + v;
        return (d - v < 0) ? 0 : d - v;
    endfunction

    always @(posedge rclk) cyc <= cyc + 1;

    // Controller model: one-cycle ack pulse ack_dly cycles after req is seen.
    always @(negedge rclk) begin
        if (!rst_n || !req) begin
            reqcyc = 0;
            ack    = 1'b0;
        end else begin
            reqcyc++;
            ack = (reqcyc == ack_dly + 1);
        end
    end

    // Monitor: accumulate activity, compare against the queued expectation on each done pulse.
    always @(negedge rclk) begin
        if (!rst_n) begin
            mon_req = 0; mon_dll = 0; mon_load = 0;
        end else begin
            if (req)    mon_req++;
            if (!dll_n) mon_dll++;
            if (load)   mon_load++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("latency", cyc - e.start_cyc, e.lat);
                    check("req_cycles", mon_req, e.req_hi);
                    check("req_low_at_done", req, 0);
                    check("dll_low_cycles", mon_dll, e.dll_lo);
                    check("load_pulses", mon_load, e.loads);
                    check("tap_l", dly_l, e.l);
                    check("tap_h", dly_h, e.h);
                    check("timeout_flag", tout, e.to);
                    check("done_8bit", done8, 1);
                    check("tap_l_8bit", dly_l8, e.l);
                    check("tap_h_8bit", dly_h8, 64);
                end
                mon_req = 0; mon_dll = 0; mon_load = 0;
            end
        end
    end

    task automatic do_update(input logic [1:0] t, input logic [1:0] vl, input logic dl,
                             input logic [1:0] vh, input logic dh, input int d, input int hold);
        exp_t e;
        bit   timed, got;
        int   act, reqs;
        timed = (d > 254);
        act   = timed ? 0 : (t == 2'b00 ? 8 : (t == 2'b01 ? 1 : 0));
        if (!timed && t == 2'b01) begin
            m_l = step(m_l, int'(vl), dl);
            m_h = step(m_h, int'(vh), dh);
        end
        m_to     = m_to | timed;
        e.l      = m_l;
        e.h      = m_h;
        e.to     = m_to;
        e.dll_lo = (!timed && t == 2'b00) ? 8 : 0;
        e.loads  = (!timed && t == 2'b01) ? 1 : 0;
        e.req_hi = timed ? 255 : d + 1 + act + 16;
        e.lat    = timed ? 257 : d + act + 19;
        @(negedge rclk);
        e.start_cyc = cyc;
        sb_q.push_back(e);
        ack_dly = d;
        typ = t; val_l = vl; dir_l = dl; val_h = vh; dir_h = dh;
        update_start = 1'b1;
        @(negedge rclk);
        typ = 2'($urandom); val_l = 2'($urandom); val_h = 2'($urandom);
        dir_l = 1'($urandom); dir_h = 1'($urandom);
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge rclk);
        end
        if (!got) check("done_wait", 0, 1);
        reqs = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge rclk);
            if (req) reqs++;
        end
        if (hold > 0) check("no_retrigger", reqs, 0);
        update_start = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
    endtask

    task automatic rand_update();
        do_update(2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                  int'($urandom_range(0, 5)), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, req, 0);
        check({tag, "_dll_n"}, dll_n, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_load"}, load, 0);
        check({tag, "_timeout"}, tout, 0);
        check({tag, "_tap_l"}, dly_l, 64);
        check({tag, "_tap_h"}, dly_h, 64);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; update_start = 1'b0;
        typ = '0; val_l = '0; val_h = '0; dir_l = 1'b0; dir_h = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge rclk);
        rst_n = 1'b1;
        @(negedge rclk);

        do_update(2'b01, 2'd2, 1'b1, 2'd1, 1'b0, 3, 0);
        do_update(2'b00, 2'd0, 1'b0, 2'd0, 1'b0, 0, 0);
        do_update(2'b10, 2'd3, 1'b1, 2'd3, 1'b1, 1, 0);
        for (int i = 0; i < 25; i++)
            do_update(2'b01, 2'd3, 1'b1, 2'd3, 1'b0, int'($urandom_range(0, 2)), 0);
        do_update(2'b11, 2'd0, 1'b0, 2'd0, 1'b0, 0, 10);
        do_update(2'b01, 2'd3, 1'b0, 2'd3, 1'b1, 1000, 0);
        for (int i = 0; i < 20; i++) rand_update();

        // Abort a DLL update mid-pulse with an asynchronous reset.
        @(negedge rclk);
        ack_dly = 0; typ = 2'b00; update_start = 1'b1;
        repeat (4) @(negedge rclk);
        check("dll_low_before_reset", dll_n, 0);
        #1 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        update_start = 1'b0;
        sb_q.delete();
        m_l = 64; m_h = 64; m_to = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
        rst_n = 1'b1;
        @(negedge rclk);

        do_update(2'b00, 2'd0, 1'b0, 2'd0, 1'b0, 2, 0);
        for (int i = 0; i < 8; i++) rand_update();

        repeat (5) @(negedge rclk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipsl_ddrphy_update_exec.md
Name: ipsl_ddrphy_update_exec

Overview:
- PHY-side responder for PHY-initiated updates.
- Accepts update_start with its type and DQS drift compensation.
- Obtains a traffic-quiet window from the memory controller over the DFI phyupd handshake.
- Executes the update: DLL re-lock pulse or DQS read-delay tap adjustment. Manual updates only take the window.
- Returns ddrphy_update_done to the update controller.

Parameters:
- DATA_WIDTH, "16BIT", "16BIT" or "8BIT"; with "8BIT" the high lane is never adjusted.
- DLL_PULSE_CYC, 8, number of cycles dll_update_n is held low.
- SETTLE_CYC, 16, quiet cycles after an action before done is returned.
- DLY_INIT, 8'd64, reset value of both tap registers.
- DLY_MAX, 8'd127, upper saturation limit for tap values.
- ACK_TIMEOUT, 255, maximum number of cycles to wait for dfi_phyupd_ack.

Ports:
- rclk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- update_start  in  1  update request level, held until done is seen
- ddrphy_update_type  in  2  00 DLL, 01 DQS drift, 10/11 manual
- ddrphy_update_comp_val_l  in  2  low-lane tap step
- ddrphy_update_comp_dir_l  in  1  low-lane direction: 1 increments, 0 decrements
- ddrphy_update_comp_val_h  in  2  high-lane tap step
- ddrphy_update_comp_dir_h  in  1  high-lane direction
- ddrphy_update_done  out  1  single-cycle completion pulse
- dfi_phyupd_req  out  1  request to the controller
- dfi_phyupd_ack  in  1  quiet window granted
- dll_update_n  out  1  active-low DLL update pulse
- dqs_rd_dly_l  out  8  low-lane read-DQS tap value
- dqs_rd_dly_h  out  8  high-lane read-DQS tap value
- dqs_dly_load  out  1  single-cycle load strobe for the tap values
- upd_timeout  out  1  sticky flag: ack timed out

Behaviour:
- Clocking and reset: one clock, rclk; asynchronous active-low reset, rst_n.
- Reset values:
  - state IDLE; done=0, req=0, dll_update_n=1, dqs_dly_load=0, upd_timeout=0.
  - dqs_rd_dly_l = dqs_rd_dly_h = DLY_INIT.
  - All counters 0.
- States: IDLE, REQ, DLL_PULSE, DQS_ADJ, SETTLE, DONE, WAIT_LOW.
- IDLE:
  - update_start=1 captures type, val_l, dir_l, val_h and dir_h into registers on the same edge.
  - Next cycle: state REQ, dfi_phyupd_req=1.
  - Inputs are ignored after capture.
- REQ:
  - The timeout counter increments each cycle.
  - ack=1 goes to DLL_PULSE (type 00), DQS_ADJ (type 01) or SETTLE (10/11).
  - If the counter reaches ACK_TIMEOUT without ack: req drops, upd_timeout sets (cleared only by reset), state DONE, no action performed.
- DLL_PULSE:
  - dll_update_n=0 for exactly DLL_PULSE_CYC cycles, then returns to 1.
  - State then moves to SETTLE.
- DQS_ADJ (one cycle):
  - Each lane is updated as dly = dir ? min(dly+val, DLY_MAX) : max(dly-val, 0).
  - Arithmetic is computed 9 bits wide, no wrap.
  - val=0 leaves the lane unchanged.
  - High lane is untouched when DATA_WIDTH="8BIT".
  - dqs_dly_load=1 for this cycle only. The load strobe coincides with the new tap values, which are registered on the same edge.
  - State then moves to SETTLE.
- SETTLE:
  - SETTLE_CYC cycles, req still high.
  - Then req drops and state moves to DONE.
- DONE:
  - ddrphy_update_done=1 for exactly one cycle.
  - State then moves to WAIT_LOW.
- WAIT_LOW:
  - Stays until update_start=0, then IDLE.
  - Prevents a stale update_start level from retriggering an update.
- ack deasserting early in DLL_PULSE, DQS_ADJ or SETTLE is ignored; the sequence completes.
- Latency from the update_start edge to done (with ack returned on the first REQ cycle):
  - manual: 1+1+SETTLE_CYC+1
  - DLL: 1+1+DLL_PULSE_CYC+SETTLE_CYC+1
  - DQS: 1+1+1+SETTLE_CYC+1
- Reset mid-operation returns everything to the reset values immediately; tap values also return to DLY_INIT.

Optional Feature:
- Macro: IPSL_DDRPHY_UPD_STATS_EN.
- When defined:
  - Adds outputs upd_cnt_dll, upd_cnt_dqs, upd_cnt_man (each 16-bit, saturating at 16'hFFFF).
  - Each counter increments on the DONE cycle of a non-timed-out update of its type.
  - Counters reset to 0.
- When not defined: these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Type 01, val_l=2, dir_l=1, val_h=1, dir_h=0, ack after 3 cycles -> taps 66/63, one dqs_dly_load pulse, one done pulse, req low before done.
- Type 00 with ack immediate -> dll_update_n low exactly 8 cycles, done 27 cycles after update_start.
- Taps at 127 with +3, and at 1 with -3 -> saturate to 127 and 0; no wrap.
- ack never asserted -> req drops after 255 cycles, upd_timeout=1, done pulses, taps unchanged.
- update_start held high 10 cycles after done -> no second req until start falls and rises again; DATA_WIDTH="8BIT" with val_h=3 -> dqs_rd_dly_h stays 64.
- rst_n asserted during DLL_PULSE -> dll_update_n=1, req=0 and state IDLE asynchronously; a new request then completes normally.
